// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul datapath: feeder state encoding and
// operand-geometry helpers used by the feeder and the calculator benches.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feeder_state_e;

  // Number of elements that fit side by side on one calculator bus.
  function automatic int calc_max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  // LSB of element (row, col) inside a row-major flattened matrix.
  function automatic int elem_lsb(input int row, input int col, input int dim,
                                  input int data_width);
    return ((row * dim) + col) * data_width;
  endfunction

endpackage

// File: rtl/matmul_skew_lane.sv
// One skewed lane: picks element (step - LANE) of a latched row/column,
// or zero when that index falls outside the vector.
module matmul_skew_lane #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_DIM    = 2,
  parameter int LANE       = 0,
  parameter int STEP_W     = 2
) (
  input  logic [MAX_DIM*DATA_WIDTH-1:0] i_vec,
  input  logic [STEP_W-1:0]             i_step,
  output logic [DATA_WIDTH-1:0]         o_elem
);

  logic [DATA_WIDTH-1:0] w_elem;

  // At most one position matches the step, so OR-ing gated elements forms the mux.
  always_comb begin
    w_elem = '0;
    for (int j = 0; j < MAX_DIM; j++) begin
      w_elem = w_elem | (i_vec[j*DATA_WIDTH +: DATA_WIDTH]
                         & {DATA_WIDTH{i_step == STEP_W'(j + LANE)}});
    end
  end

  assign o_elem = w_elem;

endmodule

// File: rtl/matmul_operand_feeder.sv
// Latches A/B operands on start and streams them as diagonal wavefronts into
// matmul_calculator, then waits for its done and reports completion/timeout.
module matmul_operand_feeder
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 16,
  parameter int DRAIN_MAX  = 8,
  localparam int MAX_DIM   = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int MAT_W     = DATA_WIDTH * MAX_DIM * MAX_DIM,
  localparam int STEP_W    = $clog2(2 * MAX_DIM)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [MAT_W-1:0]     a_mat_i,
  input  logic [MAT_W-1:0]     b_mat_i,
  input  logic                 array_done_i,
  output logic [BUS_WIDTH-1:0] a_o,
  output logic [BUS_WIDTH-1:0] b_o,
  output logic                 start_bit_o,
  output logic                 mode_bit_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [STEP_W-1:0]    step_o
);

  localparam int WAIT_W = $clog2(DRAIN_MAX + 1);
  localparam logic [STEP_W-1:0] LAST_K     = STEP_W'(2 * MAX_DIM - 2);
  localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(DRAIN_MAX - 1);

  feeder_state_e          r_state;
  logic [MAT_W-1:0]       r_a_mat;
  logic [MAT_W-1:0]       r_b_mat;
  logic [STEP_W-1:0]      r_k;
  logic [WAIT_W-1:0]      r_wait;
  logic [BUS_WIDTH-1:0]   r_a_bus;
  logic [BUS_WIDTH-1:0]   r_b_bus;
  logic                   r_start_bit;
  logic                   r_mode;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic                   w_accept;
  logic [MAT_W-1:0]       w_a_src;
  logic [MAT_W-1:0]       w_b_src;
  logic [STEP_W-1:0]      w_k_src;
  logic [BUS_WIDTH-1:0]   w_a_bus;
  logic [BUS_WIDTH-1:0]   w_b_bus;

  // On accept the k=0 wavefront is taken from the inputs so it is registered at T+1.
  always_comb begin
    w_accept = start_i & ((r_state == ST_IDLE) | (r_state == ST_DONE));
    if (w_accept) begin
      w_a_src = a_mat_i;
      w_b_src = b_mat_i;
      w_k_src = '0;
    end else begin
      w_a_src = r_a_mat;
      w_b_src = r_b_mat;
      w_k_src = r_k + STEP_W'(1);
    end
  end

  for (genvar g_l = 0; g_l < MAX_DIM; g_l++) begin : g_lane
    logic [MAX_DIM*DATA_WIDTH-1:0] w_a_row;
    logic [MAX_DIM*DATA_WIDTH-1:0] w_b_col;

    for (genvar g_j = 0; g_j < MAX_DIM; g_j++) begin : g_elem
      localparam int A_LSB = elem_lsb(g_l, g_j, MAX_DIM, DATA_WIDTH);
      localparam int B_LSB = elem_lsb(g_j, g_l, MAX_DIM, DATA_WIDTH);
      assign w_a_row[g_j*DATA_WIDTH +: DATA_WIDTH] = w_a_src[A_LSB +: DATA_WIDTH];
      assign w_b_col[g_j*DATA_WIDTH +: DATA_WIDTH] = w_b_src[B_LSB +: DATA_WIDTH];
    end

    matmul_skew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_DIM    (MAX_DIM),
      .LANE       (g_l),
      .STEP_W     (STEP_W)
    ) u_a_lane (
      .i_vec  (w_a_row),
      .i_step (w_k_src),
      .o_elem (w_a_bus[g_l*DATA_WIDTH +: DATA_WIDTH])
    );

    matmul_skew_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_DIM    (MAX_DIM),
      .LANE       (g_l),
      .STEP_W     (STEP_W)
    ) u_b_lane (
      .i_vec  (w_b_col),
      .i_step (w_k_src),
      .o_elem (w_b_bus[g_l*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Control FSM with registered outputs; reset overrides every state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_a_mat     <= '0;
      r_b_mat     <= '0;
      r_k         <= '0;
      r_wait      <= '0;
      r_a_bus     <= '0;
      r_b_bus     <= '0;
      r_start_bit <= 1'b0;
      r_mode      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_start_bit <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_a_mat     <= a_mat_i;
            r_b_mat     <= b_mat_i;
            r_mode      <= mode_i;
            r_err       <= 1'b0;
            r_k         <= '0;
            r_a_bus     <= w_a_bus;
            r_b_bus     <= w_b_bus;
            r_start_bit <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_FEED;
          end else begin
            r_a_bus <= '0;
            r_b_bus <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_FEED: begin
          if (r_k == LAST_K) begin
            r_a_bus <= '0;
            r_b_bus <= '0;
            r_wait  <= '0;
            r_state <= ST_DRAIN;
          end else begin
            r_k     <= w_k_src;
            r_a_bus <= w_a_bus;
            r_b_bus <= w_b_bus;
          end
        end
        ST_DRAIN: begin
          r_a_bus <= '0;
          r_b_bus <= '0;
          // Completion is checked first so a done on the limit cycle is not an error.
          if (array_done_i) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else if (r_wait == DRAIN_LAST) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        default: begin
          r_a_bus <= '0;
          r_b_bus <= '0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a_o         = r_a_bus;
  assign b_o         = r_b_bus;
  assign start_bit_o = r_start_bit;
  assign mode_bit_o  = r_mode;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign step_o      = r_k;

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Bench for matmul_operand_feeder: directed and random operations checked
// against a wavefront model computed from the matrices with plain indexing.
module tb_matmul_operand_feeder;

  localparam int DW    = 8;
  localparam int MD    = 2;
  localparam int DRAIN = 8;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic        mode_i;
  logic [31:0] a_mat_i;
  logic [31:0] b_mat_i;
  logic        array_done_i;
  logic [15:0] a_o;
  logic [15:0] b_o;
  logic        start_bit_o;
  logic        mode_bit_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  step_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] ma [MD][MD];
  logic [7:0] mb [MD][MD];

  matmul_operand_feeder #(
    .DATA_WIDTH (DW),
    .BUS_WIDTH  (16),
    .DRAIN_MAX  (DRAIN)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .a_mat_i      (a_mat_i),
    .b_mat_i      (b_mat_i),
    .array_done_i (array_done_i),
    .a_o          (a_o),
    .b_o          (b_o),
    .start_bit_o  (start_bit_o),
    .mode_bit_o   (mode_bit_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .step_o       (step_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_mat(input bit is_a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++)
        v[(i*MD+j)*DW +: DW] = is_a ? ma[i][j] : mb[i][j];
    return v;
  endfunction

  // Lane l carries A[l][k-l] (or B[k-l][l]) when that index is in range.
  function automatic logic [15:0] exp_bus(input bit is_a, input int k);
    logic [15:0] v;
    v = '0;
    for (int l = 0; l < MD; l++) begin
      int idx;
      idx = k - l;
      if (idx >= 0 && idx < MD) v[l*DW +: DW] = is_a ? ma[l][idx] : mb[idx][l];
    end
    return v;
  endfunction

  task automatic randomize_mats();
    for (int i = 0; i < MD; i++)
      for (int j = 0; j < MD; j++) begin
        ma[i][j] = 8'($urandom);
        mb[i][j] = 8'($urandom);
      end
  endtask

  // One full operation; returns in the DONE cycle. done_at in 1..DRAIN pulses
  // array_done_i on that DRAIN cycle, anything else lets it time out.
  task automatic run_op(input bit m, input int done_at, input bit inject);
    a_mat_i = pack_mat(1'b1);
    b_mat_i = pack_mat(1'b0);
    mode_i  = m;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k <= 2*MD-2; k++) begin
      if (inject && k == 1) begin
        start_i = 1'b1;
        a_mat_i = ~a_mat_i;
        b_mat_i = $urandom;
        mode_i  = ~m;
      end
      check("feed_a", 32'(a_o), 32'(exp_bus(1'b1, k)));
      check("feed_b", 32'(b_o), 32'(exp_bus(1'b0, k)));
      check("feed_start_bit", 32'(start_bit_o), 32'(k == 0));
      check("feed_step", 32'(step_o), 32'(k));
      check("feed_busy", 32'(busy_o), 32'd1);
      check("feed_mode", 32'(mode_bit_o), 32'(m));
      check("feed_err", 32'(err_o), 32'd0);
      tick();
      start_i = 1'b0;
    end
    for (int j = 1; j <= DRAIN; j++) begin
      check("drain_a", 32'(a_o), 32'd0);
      check("drain_b", 32'(b_o), 32'd0);
      check("drain_busy", 32'(busy_o), 32'd1);
      check("drain_done", 32'(done_o), 32'd0);
      check("drain_start_bit", 32'(start_bit_o), 32'd0);
      array_done_i = (j == done_at);
      tick();
      array_done_i = 1'b0;
      if (j == done_at) break;
    end
    check("done_pulse", 32'(done_o), 32'd1);
    check("done_busy", 32'(busy_o), 32'd0);
    check("done_err", 32'(err_o), 32'((done_at < 1) || (done_at > DRAIN)));
    check("done_mode", 32'(mode_bit_o), 32'(m));
  endtask

  initial begin
    rst_ni       = 1'b0;
    start_i      = 1'b0;
    mode_i       = 1'b0;
    a_mat_i      = '0;
    b_mat_i      = '0;
    array_done_i = 1'b0;
    tick();
    tick();
    check("rst_a", 32'(a_o), 32'd0);
    check("rst_b", 32'(b_o), 32'd0);
    check("rst_start_bit", 32'(start_bit_o), 32'd0);
    check("rst_mode", 32'(mode_bit_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_step", 32'(step_o), 32'd0);
    rst_ni = 1'b1;
    tick();

    // done from the array while idle is ignored
    array_done_i = 1'b1;
    tick();
    array_done_i = 1'b0;
    check("idle_done_ignored", 32'(done_o), 32'd0);
    check("idle_busy", 32'(busy_o), 32'd0);

    // Basic feed with the reference matrices, completion on the 2nd DRAIN cycle
    ma[0][0] = 8'd1; ma[0][1] = 8'd2; ma[1][0] = 8'd3; ma[1][1] = 8'd4;
    mb[0][0] = 8'd5; mb[0][1] = 8'd6; mb[1][0] = 8'd7; mb[1][1] = 8'd8;
    a_mat_i = pack_mat(1'b1);
    b_mat_i = pack_mat(1'b0);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("k0_a", 32'(a_o), 32'h0001);
    check("k0_b", 32'(b_o), 32'h0005);
    check("k0_start_bit", 32'(start_bit_o), 32'd1);
    tick();
    check("k1_a", 32'(a_o), 32'h0302);
    check("k1_b", 32'(b_o), 32'h0607);
    check("k1_start_bit", 32'(start_bit_o), 32'd0);
    tick();
    check("k2_a", 32'(a_o), 32'h0400);
    check("k2_b", 32'(b_o), 32'h0800);
    tick();
    check("drain1_a", 32'(a_o), 32'd0);
    check("drain1_b", 32'(b_o), 32'd0);
    tick();
    array_done_i = 1'b1;
    tick();
    array_done_i = 1'b0;
    check("basic_done", 32'(done_o), 32'd1);
    check("basic_busy", 32'(busy_o), 32'd0);
    check("basic_err", 32'(err_o), 32'd0);
    tick();
    check("basic_done_one_cycle", 32'(done_o), 32'd0);

    // Timeout, then err stays sticky while idle
    run_op(1'b0, 0, 1'b0);
    tick();
    check("err_sticky", 32'(err_o), 32'd1);
    check("err_idle_done", 32'(done_o), 32'd0);

    // New start clears err; start while busy is ignored; done on the limit cycle wins
    randomize_mats();
    run_op(1'b0, DRAIN, 1'b1);

    // Back-to-back start in the DONE cycle with mode 1
    randomize_mats();
    run_op(1'b1, 3, 1'b0);
    tick();
    check("mode_held_idle", 32'(mode_bit_o), 32'd1);
    tick();
    check("mode_held_idle2", 32'(mode_bit_o), 32'd1);

    // Reset in the middle of FEED
    randomize_mats();
    a_mat_i = pack_mat(1'b1);
    b_mat_i = pack_mat(1'b0);
    mode_i  = 1'b1;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    check("pre_rst_step", 32'(step_o), 32'd1);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("midrst_a", 32'(a_o), 32'd0);
    check("midrst_b", 32'(b_o), 32'd0);
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_mode", 32'(mode_bit_o), 32'd0);
    check("midrst_step", 32'(step_o), 32'd0);
    check("midrst_start_bit", 32'(start_bit_o), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_no_done", 32'(done_o), 32'd0);
      check("post_rst_idle", 32'(busy_o), 32'd0);
    end

    // Random operations, some back-to-back
    for (int n = 0; n < 8; n++) begin
      randomize_mats();
      run_op(1'($urandom), int'($urandom_range(0, 9)), 1'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        tick();
        check("rand_done_drop", 32'(done_o), 32'd0);
      end
    end
    tick();
    check("final_idle_busy", 32'(busy_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
